// File: rtl/player_pkg.sv
// Shared types and fixed-point constants for the multi-voice clip player.
package player_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } voice_state_e;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAC_W     = 16;
  localparam int unsigned FRAC_SEL_W = 8;
  localparam int unsigned GAIN_W     = 8;
  localparam int unsigned GAIN_SHIFT = 7;
  localparam int unsigned STEP_W     = 17;

  // round(65536 * 2^(s/12)) for one octave of semitones
  localparam logic [STEP_W-1:0] SEMI_STEP [12] = '{
    17'd65536, 17'd69433, 17'd73562, 17'd77936, 17'd82570, 17'd87480,
    17'd92682, 17'd98193, 17'd104032, 17'd110218, 17'd116772, 17'd123715
  };

endpackage

// File: rtl/player_voice_ctrl.sv
// Per-voice control: pending trig/stop flags, play state, phase accumulator and
// pitch step generation.
module player_voice_ctrl
  import player_pkg::*;
#(
  parameter int unsigned CLIP_LEN  = 1024,
  parameter int unsigned NOTE_BITS = 7,
  parameter int unsigned TOP_OCT   = 8,
  localparam int unsigned IDX_W    = $clog2(CLIP_LEN),
  localparam int unsigned PHASE_W  = IDX_W + FRAC_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic                  adv_i,
  input  logic                  trig_i,
  input  logic                  stop_i,
  input  logic [NOTE_BITS-1:0]  note_i,
  input  logic [GAIN_W-1:0]     gain_i,
  input  logic                  loop_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic [FRAC_SEL_W-1:0] frac_o,
  output logic [GAIN_W-1:0]     gain_o,
  output logic                  loop_o,
  output logic                  active_o
);

  voice_state_e         state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0]    step_q, step_d, step_new;
  logic [GAIN_W-1:0]    gain_q, gain_d;
  logic                 loop_q, loop_d;
  logic                 trig_pend_q, trig_pend_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [PHASE_W:0]     sum;
  logic [31:0]          oct, shift;
  logic [3:0]           semi;

  always_comb begin
    oct  = 32'(note_i) / 32'd12;
    semi = 4'(32'(note_i) % 32'd12);
    if (oct > TOP_OCT) oct = TOP_OCT;
    shift    = TOP_OCT - oct;
    step_new = SEMI_STEP[semi] >> shift;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_d      = step_q;
    gain_d      = gain_q;
    loop_d      = loop_q;
    trig_pend_d = trig_pend_q | trig_i;
    stop_pend_d = stop_pend_q | stop_i;
    // Carry out of the top bit marks the end of the clip in one-shot mode
    sum         = {1'b0, phase_q} + (PHASE_W + 1)'(step_q);
    if (frame_start_i) begin
      trig_pend_d = 1'b0;
      stop_pend_d = 1'b0;
      if (trig_pend_q || trig_i) begin
        state_d = PLAY;
        phase_d = '0;
        step_d  = step_new;
        gain_d  = gain_i;
        loop_d  = loop_i;
      end else if (stop_pend_q || stop_i) begin
        state_d = IDLE;
      end
    end else if (adv_i && state_q == PLAY) begin
      phase_d = sum[PHASE_W-1:0];
      if (!loop_q && sum[PHASE_W]) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      gain_q      <= '0;
      loop_q      <= 1'b0;
      trig_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      gain_q      <= gain_d;
      loop_q      <= loop_d;
      trig_pend_q <= trig_pend_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign idx_o    = phase_q[PHASE_W-1:FRAC_W];
  assign frac_o   = phase_q[FRAC_W-1:FRAC_W-FRAC_SEL_W];
  assign gain_o   = gain_q;
  assign loop_o   = loop_q;
  assign active_o = (state_q == PLAY);

endmodule

// File: rtl/multi_voice_player.sv
// Multi-voice clip player: voices are visited one per cycle in each frame on a
// shared interpolate/gain/accumulate datapath, then the mix is saturated out.
module multi_voice_player
  import player_pkg::*;
#(
  parameter int unsigned CLIP_LEN  = 1024,
  parameter int unsigned N_VOICES  = 4,
  parameter int unsigned NOTE_BITS = 7,
  parameter int unsigned TOP_OCT   = 8,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                               mclk,
  input  logic                               rst,
  input  shortint                            data_buffer [0:CLIP_LEN-1],
  input  logic [N_VOICES-1:0][NOTE_BITS-1:0] note_i,
  input  logic [N_VOICES-1:0][GAIN_W-1:0]    gain_i,
  input  logic [N_VOICES-1:0]                loop_i,
  input  logic [N_VOICES-1:0]                trig_i,
  input  logic [N_VOICES-1:0]                stop_i,
  output shortint                            sample_out,
  output logic                               sample_valid,
  output logic [N_VOICES-1:0]                voice_active
);

  localparam int unsigned IDX_W = $clog2(CLIP_LEN);
  localparam int unsigned FC_W  = $clog2(FRAME_LEN);
  localparam int unsigned ACC_W = SAMPLE_W + 1 + $clog2(N_VOICES) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  if (N_VOICES + 2 > FRAME_LEN) begin : g_bad_cfg
    $error("multi_voice_player: FRAME_LEN too short for N_VOICES");
  end

  logic [FC_W-1:0]                      fc_q, fc_d;
  logic signed [ACC_W-1:0]              acc_q, acc_d;
  logic signed [SAMPLE_W-1:0]           sample_q, sample_d;
  logic                                 valid_q;
  logic [N_VOICES-1:0]                  v_adv, v_loop;
  logic [N_VOICES-1:0][IDX_W-1:0]       v_idx;
  logic [N_VOICES-1:0][FRAC_SEL_W-1:0]  v_frac;
  logic [N_VOICES-1:0][GAIN_W-1:0]      v_gain;

  for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
    assign v_adv[v] = (fc_q == FC_W'(v + 1));
    player_voice_ctrl #(
      .CLIP_LEN (CLIP_LEN),
      .NOTE_BITS(NOTE_BITS),
      .TOP_OCT  (TOP_OCT)
    ) u_ctrl (
      .clk_i        (mclk),
      .rst_i        (rst),
      .frame_start_i(fc_q == '0),
      .adv_i        (v_adv[v]),
      .trig_i       (trig_i[v]),
      .stop_i       (stop_i[v]),
      .note_i       (note_i[v]),
      .gain_i       (gain_i[v]),
      .loop_i       (loop_i[v]),
      .idx_o        (v_idx[v]),
      .frac_o       (v_frac[v]),
      .gain_o       (v_gain[v]),
      .loop_o       (v_loop[v]),
      .active_o     (voice_active[v])
    );
  end

  logic [IDX_W-1:0]        sel_idx, idx_next;
  logic [FRAC_SEL_W-1:0]   sel_frac;
  logic [GAIN_W-1:0]       sel_gain;
  logic                    sel_loop, sel_active, any_adv;
  logic signed [15:0]      s0, s1;
  logic signed [16:0]      diff, y;
  logic signed [25:0]      prod_f, scaled;
  logic signed [ACC_W-1:0] contrib;

  always_comb begin
    sel_idx    = '0;
    sel_frac   = '0;
    sel_gain   = '0;
    sel_loop   = 1'b0;
    sel_active = 1'b0;
    any_adv    = 1'b0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (v_adv[v]) begin
        sel_idx    = v_idx[v];
        sel_frac   = v_frac[v];
        sel_gain   = v_gain[v];
        sel_loop   = v_loop[v];
        sel_active = voice_active[v];
        any_adv    = 1'b1;
      end
    end
    idx_next = sel_idx + 1'b1;
    s0       = data_buffer[sel_idx];
    // One-shot voices hold the last sample instead of blending into data[0]
    s1       = (!sel_loop && sel_idx == IDX_W'(CLIP_LEN - 1)) ? s0 : data_buffer[idx_next];
    diff     = {s1[15], s1} - {s0[15], s0};
    prod_f   = diff * $signed({1'b0, sel_frac});
    y        = {s0[15], s0} + 17'(prod_f >>> 8);
    scaled   = y * $signed({1'b0, sel_gain});
    contrib  = sel_active ? ACC_W'(scaled >>> GAIN_SHIFT) : '0;
  end

  always_comb begin
    fc_d     = (fc_q == FC_W'(FRAME_LEN - 1)) ? '0 : fc_q + 1'b1;
    acc_d    = acc_q;
    sample_d = sample_q;
    if (fc_q == '0) acc_d = '0;
    else if (any_adv) acc_d = acc_q + contrib;
    if (fc_q == FC_W'(N_VOICES)) begin
      if (acc_d > SAT_MAX) sample_d = 16'sd32767;
      else if (acc_d < SAT_MIN) sample_d = -16'sd32768;
      else sample_d = 16'(acc_d);
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      fc_q     <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      fc_q     <= fc_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= (fc_q == FC_W'(N_VOICES));
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;

endmodule
